// File: rtl/drop_sched_pkg.sv
// Shared types and constants for the chart-driven drop scheduler.
// The FSM state set, the chart word layout and the two control keycodes live here.
package drop_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    LAUNCH = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic        last;
    logic [1:0]  lane;
    logic [11:0] launch_frame;
  } chart_entry_t;

  localparam logic [7:0]  KEY_START = 8'h2c;
  localparam logic [7:0]  KEY_ABORT = 8'h01;
  localparam logic [11:0] FRAME_MAX = 12'hFFF;

  // Pool is at most 16 slots, so callers zero-extend their masks to 16 bits.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/drop_scheduler_slot_alloc.sv
// Lowest-index free-slot picker for the dropper pool.
// Purely combinational: busy mask in, {any_free, one-hot grant} out.
module slot_alloc #(
  parameter int NUM_SLOTS = 8
) (
  input  logic [NUM_SLOTS-1:0] i_busy,
  output logic                 o_any_free,
  output logic [NUM_SLOTS-1:0] o_grant
);

  logic [NUM_SLOTS-1:0] w_free;

  // x & -x isolates the lowest set bit, i.e. the lowest-index free slot.
  always_comb begin
    w_free     = ~i_busy;
    o_any_free = |w_free;
    o_grant    = w_free & (~w_free + NUM_SLOTS'(1));
  end

endmodule

// File: rtl/drop_scheduler.sv
// Chart sequencer: fetches notes, launches them into free dropper slots at
// their charted frame, and folds slot completions into score/combo counters.
module drop_scheduler
  import drop_sched_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int CHART_DEPTH = 32
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic [7:0]                     keycode,
  output logic [$clog2(CHART_DEPTH)-1:0] chart_addr,
  input  logic [14:0]                    chart_data,
  output logic [NUM_SLOTS-1:0]           launch,
  output logic [1:0]                     launch_lane,
  output logic                           slot_clear,
  input  logic [NUM_SLOTS-1:0]           done_valid,
  input  logic [NUM_SLOTS-1:0]           done_hit,
  output logic [15:0]                    score,
  output logic [7:0]                     combo,
  output logic [7:0]                     max_combo,
  output logic                           playing,
  output logic                           game_over
);

  localparam int AW = $clog2(CHART_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(CHART_DEPTH - 1);

  sched_state_t         r_state;
  sched_state_t         w_next;
  logic [AW-1:0]        r_ptr;
  logic [11:0]          r_frame;
  chart_entry_t         r_entry;
  chart_entry_t         w_entry;
  logic [NUM_SLOTS-1:0] r_busy;
  logic [NUM_SLOTS-1:0] r_launch;
  logic [1:0]           r_lane;
  logic                 r_slotClear;
  logic [15:0]          r_score;
  logic [7:0]           r_combo;
  logic [7:0]           r_maxCombo;
  logic                 r_playing;
  logic                 r_gameOver;

  logic                 w_abort;
  logic                 w_anyFree;
  logic [NUM_SLOTS-1:0] w_grant;
  logic                 w_doLaunch;
  logic                 w_isPlaying;
  logic                 w_nextPlaying;
  logic [NUM_SLOTS-1:0] w_hits;
  logic [NUM_SLOTS-1:0] w_misses;
  logic [4:0]           w_hitCnt;
  logic [16:0]          w_scoreSum;
  logic [8:0]           w_comboSum;
  logic [7:0]           w_comboNext;
  logic [7:0]           w_maxNext;

  slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_alloc (
    .i_busy     (r_busy),
    .o_any_free (w_anyFree),
    .o_grant    (w_grant)
  );

  assign w_entry     = chart_entry_t'(chart_data);
  assign w_abort     = (keycode == KEY_ABORT) && (r_state != IDLE);
  assign w_isPlaying = (r_state == FETCH) || (r_state == WAIT) ||
                       (r_state == LAUNCH) || (r_state == DRAIN);
  assign chart_addr  = r_ptr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (keycode == KEY_START) w_next = FETCH;
      FETCH:   w_next = WAIT;
      WAIT:    if ((r_frame >= w_entry.launch_frame) && w_anyFree) w_next = LAUNCH;
      LAUNCH:  w_next = (r_entry.last || (r_ptr == LAST_PTR)) ? DRAIN : FETCH;
      DRAIN:   if (r_busy == '0) w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
    // Abort outranks every other transition, including the DRAIN/DONE exits.
    if (w_abort) w_next = IDLE;
  end

  assign w_doLaunch    = (r_state == WAIT) && (w_next == LAUNCH);
  assign w_nextPlaying = (w_next == FETCH) || (w_next == WAIT) ||
                         (w_next == LAUNCH) || (w_next == DRAIN);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_frame <= '0;
      r_entry <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WAIT) r_entry <= w_entry;
      if (w_abort || (r_state == IDLE)) begin
        r_ptr   <= '0;
        r_frame <= '0;
      end else begin
        if ((r_state == LAUNCH) && (w_next == FETCH)) r_ptr <= r_ptr + AW'(1);
        if (w_isPlaying && (r_frame != FRAME_MAX)) r_frame <= r_frame + 12'd1;
      end
    end
  end

  // Launch sets the busy bit on the same edge the WAIT->LAUNCH decision is
  // taken, so the one-hot pulse and the busy bit appear together.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_busy      <= '0;
      r_launch    <= '0;
      r_lane      <= '0;
      r_slotClear <= 1'b0;
      r_playing   <= 1'b0;
      r_gameOver  <= 1'b0;
    end else begin
      r_launch    <= w_doLaunch ? w_grant : '0;
      r_lane      <= w_doLaunch ? w_entry.lane : 2'd0;
      r_slotClear <= w_abort;
      r_playing   <= w_nextPlaying;
      r_gameOver  <= (w_next == DONE);
      if (w_abort) r_busy <= '0;
      else         r_busy <= (r_busy & ~done_valid) | (w_doLaunch ? w_grant : '0);
    end
  end

  // Only completions from busy slots count; stray pulses are dropped here.
  always_comb begin
    w_hits      = done_valid & r_busy & done_hit;
    w_misses    = done_valid & r_busy & ~done_hit;
    w_hitCnt    = popcount16(16'(w_hits));
    w_scoreSum  = {1'b0, r_score} + 17'(w_hitCnt);
    w_comboSum  = {1'b0, r_combo} + 9'(w_hitCnt);
    w_comboNext = (|w_misses) ? 8'd0 : (w_comboSum[8] ? 8'hFF : w_comboSum[7:0]);
    w_maxNext   = (w_comboNext > r_maxCombo) ? w_comboNext : r_maxCombo;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_score    <= '0;
      r_combo    <= '0;
      r_maxCombo <= '0;
    end else if (w_abort) begin
      r_score    <= '0;
      r_combo    <= '0;
      r_maxCombo <= '0;
    end else begin
      r_score    <= w_scoreSum[16] ? 16'hFFFF : w_scoreSum[15:0];
      r_combo    <= w_comboNext;
      r_maxCombo <= w_maxNext;
    end
  end

  assign launch      = r_launch;
  assign launch_lane = r_lane;
  assign slot_clear  = r_slotClear;
  assign score       = r_score;
  assign combo       = r_combo;
  assign max_combo   = r_maxCombo;
  assign playing     = r_playing;
  assign game_over   = r_gameOver;

endmodule
